imem_loader: RTL and testbench
==============================

# imem_loader

Writer side of the 128 x 32 instruction memory. It accepts a byte stream over a valid/ready handshake, assembles little-endian 32-bit instruction words, and issues one registered write per word at consecutive addresses from 0. While loading it holds the CPU (`cpu_hold`), so fetch never reads a partially programmed memory.

## Interface
- `MEM_DEPTH`, 128: instruction memory words; address width is `$clog2(MEM_DEPTH)` = 7.
- `clk` in 1: system clock; all logic is rising-edge.
- `reset` in 1: asynchronous, active-low; 0 clears all state.
- `start` in 1: one-cycle pulse that begins a load; sampled only in IDLE.
- `word_count` in 8: number of words to load, valid 1..128; latched on `start`.
- `byte_in` in 8: stream data.
- `byte_valid` in 1: `byte_in` is valid.
- `byte_ready` out 1: loader accepts a byte this cycle.
- `mem_we` out 1: write strobe to instruction memory.
- `mem_addr` out 7: write address.
- `mem_wdata` out 32: write data.
- `cpu_hold` out 1: high while state is LOAD or FLUSH.
- `done` out 1: sticky; set on successful completion, cleared by the next accepted `start`.
- `error` out 1: sticky; set when `start` has `word_count` 0 or greater than 128, cleared by the next accepted `start`.

## Operation
- Reset values: state IDLE. `byte_ready`, `mem_we`, `cpu_hold`, `done` and `error` are 0. `mem_addr`, `mem_wdata`, the byte counter and the word counter are 0.
- IDLE:
  - `start` with `word_count` in 1..128 latches the count, clears `done`/`error`, zeroes the address and the byte counter, and moves to LOAD.
  - `start` with an illegal count sets `error`, clears `done`, and stays in IDLE.
- LOAD:
  - `byte_ready` = 1.
  - A byte is accepted when `byte_valid && byte_ready`.
  - The byte counter (2 bits) selects the lane: byte 0 goes to [7:0], byte 3 to [31:24].
  - When byte 3 is accepted, the next cycle shows `mem_we` = 1 for exactly one cycle, with the assembled word and the current address.
  - The address then increments.
  - After the write of the last word (the write counter equals the latched count), move to FLUSH.
- FLUSH: one cycle with `byte_ready` = 0. Set `done` and return to IDLE.
- `start` in LOAD or FLUSH is ignored.
- Bytes presented in IDLE or FLUSH are not accepted (`byte_ready` = 0).
- `word_count` = 128 writes addresses 0..127. The address never wraps within a load because the count bounds it.
- Reset mid-load aborts immediately:
  - the partial word is discarded;
  - no write is issued;
  - `cpu_hold` drops;
  - words already written stay in memory.

## Timing
- Latency from acceptance of the 4th byte of a word to `mem_we`: 1 cycle (registered output).
- Peak throughput is 1 byte per cycle, so one write every 4 cycles. `mem_we` never occurs on consecutive cycles.
- `cpu_hold` rises in the cycle after `start` and falls in the cycle after FLUSH.
- `done` rises in that same cycle.
- `mem_addr` and `mem_wdata` hold their last values when `mem_we` = 0.

## Structure
- A shared package `cpu_pkg` holds:
  - `IMEM_DEPTH` = 128, `IMEM_AW` = 7, `INSTR_W` = 32;
  - the `loader_state_t` enum {IDLE, LOAD, FLUSH}, which the fetch and hazard logic can reference.
- A single sub-module, `byte_packer`, is natural. It takes the byte, the lane index and an accept input, and holds the 32-bit assembly register plus a word-complete pulse.
- The FSM, the counters and the write register stay in the top level.

## Test plan
- Load of 2 words:
  - stimulus: `word_count` = 2, bytes 0x78 0x56 0x34 0x12 0xEF 0xBE 0xAD 0xDE, `byte_valid` held high;
  - response: writes 0x12345678 at address 0 and 0xDEADBEEF at address 1, each one cycle after its 4th byte;
  - `done` = 1, `cpu_hold` = 0 after FLUSH.
- Gapped valid:
  - stimulus: the same stream with `byte_valid` toggling 1/0;
  - response: identical writes, no extra `mem_we`, address ordering preserved.
- Illegal count:
  - `word_count` = 0 gives `error` = 1, state stays IDLE, `byte_ready` = 0;
  - a following `start` with `word_count` = 1 clears `error`.
- Full depth:
  - stimulus: `word_count` = 128, word i = i;
  - response: the last write goes to address 127 with data 0x0000007F, exactly 128 strobes;
  - a `start` pulse mid-load is ignored.
- Reset mid-word:
  - stimulus: assert `reset` = 0 after 2 bytes of word 0;
  - response: all outputs go to reset values asynchronously, and no `mem_we` occurs;
  - a reload with `word_count` = 1 writes the fresh word at address 0.
- Back-to-back loads:
  - stimulus: a second `start` in the cycle after `done` rises;
  - response: `done` clears and the address restarts at 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared instruction-memory geometry and the loader state encoding used by the loader, fetch and hazard logic
package cpu_pkg;
  localparam int IMEM_DEPTH = 128;
  localparam int IMEM_AW = 7;
  localparam int INSTR_W = 32;
  typedef enum logic [1:0] {IDLE, LOAD, FLUSH} loader_state_t;
endpackage

// File: rtl/byte_packer.sv
// byte_packer: little-endian byte-to-word assembly (in: byte_i, lane_i, accept_i; out: word_o valid with word_done_o when lane 3 is accepted)
module byte_packer
  import cpu_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               accept_i,
  input  logic [1:0]         lane_i,
  input  logic [7:0]         byte_i,
  output logic [INSTR_W-1:0] word_o,
  output logic               word_done_o
);
  logic [23:0] asm_q;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) asm_q <= '0;
    else if (accept_i && lane_i != 2'd3) asm_q[lane_i*8 +: 8] <= byte_i;
  assign word_o = {byte_i, asm_q};
  assign word_done_o = accept_i && lane_i == 2'd3;
endmodule

// File: rtl/imem_loader.sv
// imem_loader: byte-stream instruction memory writer (in: start_i/word_count_i, byte stream; out: mem write port, cpu_hold_o, sticky done_o/error_o)
module imem_loader
  import cpu_pkg::*;
#(
  parameter int MEM_DEPTH = IMEM_DEPTH,
  localparam int AW = $clog2(MEM_DEPTH)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic [7:0]         word_count_i,
  input  logic [7:0]         byte_in_i,
  input  logic               byte_valid_i,
  output logic               byte_ready_o,
  output logic               mem_we_o,
  output logic [AW-1:0]      mem_addr_o,
  output logic [INSTR_W-1:0] mem_wdata_o,
  output logic               cpu_hold_o,
  output logic               done_o,
  output logic               error_o
);
  loader_state_t state_q, state_d;
  logic [1:0] bcnt_q;
  logic [7:0] cnt_q, wcnt_q;
  logic we_q, done_q, error_q;
  logic [AW-1:0] addr_q;
  logic [INSTR_W-1:0] wdata_q, word;
  logic accept, word_done, bad, last;
  assign byte_ready_o = state_q == LOAD;
  assign accept = byte_valid_i && byte_ready_o;
  assign bad = word_count_i == 8'd0 || word_count_i > 8'(MEM_DEPTH);
  assign last = wcnt_q + 8'd1 == cnt_q;
  byte_packer u_packer (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .accept_i   (accept),
    .lane_i     (bcnt_q),
    .byte_i     (byte_in_i),
    .word_o     (word),
    .word_done_o(word_done)
  );
  // Leaving LOAD on the final 4th byte keeps byte_ready low during the last write, so no stray byte slips in.
  always_comb
    state_d = (state_q == IDLE && start_i && !bad) ? LOAD :
              (state_q == LOAD && word_done && last) ? FLUSH :
              (state_q == FLUSH) ? IDLE : state_q;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state_q <= IDLE;
      bcnt_q  <= '0;
      cnt_q   <= '0;
      wcnt_q  <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= word_done;
      if (state_q == IDLE && start_i) begin
        done_q  <= 1'b0;
        error_q <= bad;
        if (!bad) begin
          cnt_q  <= word_count_i;
          wcnt_q <= '0;
          bcnt_q <= '0;
        end
      end
      if (accept) bcnt_q <= bcnt_q + 2'd1;
      if (word_done) begin
        addr_q  <= wcnt_q[AW-1:0];
        wdata_q <= word;
        wcnt_q  <= wcnt_q + 8'd1;
      end
      if (state_q == FLUSH) done_q <= 1'b1;
    end
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign cpu_hold_o  = state_q != IDLE;
  assign done_o      = done_q;
  assign error_o     = error_q;
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed self-checking bench for imem_loader
module tb_imem_loader;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, byte_valid = 1'b0;
  logic [7:0] word_count = '0, byte_in = '0;
  logic byte_ready, mem_we, cpu_hold, done, error;
  logic [6:0] mem_addr;
  logic [31:0] mem_wdata;
  int passed = 0, total = 0, wr_cnt = 0, consec = 0, base = 0;
  logic prev_we = 1'b0;
  logic [31:0] shadow [128];
  logic [7:0] stream [8] = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};

  imem_loader dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .start_i     (start),
    .word_count_i(word_count),
    .byte_in_i   (byte_in),
    .byte_valid_i(byte_valid),
    .byte_ready_o(byte_ready),
    .mem_we_o    (mem_we),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .cpu_hold_o  (cpu_hold),
    .done_o      (done),
    .error_o     (error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_we) begin
      wr_cnt <= wr_cnt + 1;
      if (prev_we) consec <= consec + 1;
      shadow[mem_addr] <= mem_wdata;
    end
    prev_we <= mem_we;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [7:0] wc);
    word_count = wc;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    int n;
    byte_in = b;
    byte_valid = 1'b1;
    n = 0;
    while (!byte_ready && n < 20) begin
      tick();
      n++;
    end
    if (n == 20) chk("ready_timeout", 32'd0, 32'd1);
    tick();
  endtask

  task automatic send_word(input logic [31:0] w);
    send(w[7:0]);
    send(w[15:8]);
    send(w[23:16]);
    send(w[31:24]);
  endtask

  initial begin
    #2;
    chk("rst_ready", byte_ready, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_hold", cpu_hold, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    base = wr_cnt;
    pulse_start(8'd2);
    chk("t1_hold", cpu_hold, 1);
    chk("t1_ready", byte_ready, 1);
    send_word(32'h12345678);
    chk("t1_we0", mem_we, 1);
    chk("t1_addr0", mem_addr, 0);
    chk("t1_data0", mem_wdata, 32'h12345678);
    send_word(32'hDEADBEEF);
    chk("t1_we1", mem_we, 1);
    chk("t1_addr1", mem_addr, 1);
    chk("t1_data1", mem_wdata, 32'hDEADBEEF);
    chk("t1_flush_ready", byte_ready, 0);
    chk("t1_flush_hold", cpu_hold, 1);
    byte_valid = 1'b0;
    tick();
    chk("t1_done", done, 1);
    chk("t1_hold_end", cpu_hold, 0);
    chk("t1_we_end", mem_we, 0);
    chk("t1_addr_hold", mem_addr, 1);
    chk("t1_data_hold", mem_wdata, 32'hDEADBEEF);
    chk("t1_strobes", wr_cnt - base, 2);

    base = wr_cnt;
    shadow[0] = '0;
    shadow[1] = '0;
    pulse_start(8'd2);
    chk("t2_done_clr", done, 0);
    for (int i = 0; i < 8; i++) begin
      send(stream[i]);
      if (i == 3) begin
        chk("t2_we0", mem_we, 1);
        chk("t2_addr0", mem_addr, 0);
      end
      byte_valid = 1'b0;
      tick();
      chk("t2_no_extra_we", mem_we, 0);
    end
    chk("t2_done", done, 1);
    chk("t2_strobes", wr_cnt - base, 2);
    chk("t2_mem0", shadow[0], 32'h12345678);
    chk("t2_mem1", shadow[1], 32'hDEADBEEF);

    pulse_start(8'd0);
    chk("t3_err0", error, 1);
    chk("t3_done_clr", done, 0);
    chk("t3_ready", byte_ready, 0);
    chk("t3_hold", cpu_hold, 0);
    pulse_start(8'd129);
    chk("t3_err129", error, 1);
    pulse_start(8'd1);
    chk("t3_err_clr", error, 0);
    chk("t3_hold1", cpu_hold, 1);
    send_word(32'hCAFEF00D);
    chk("t3_addr", mem_addr, 0);
    chk("t3_data", mem_wdata, 32'hCAFEF00D);
    byte_valid = 1'b0;
    tick();
    chk("t3_done", done, 1);

    base = wr_cnt;
    consec = 0;
    pulse_start(8'd128);
    for (int i = 0; i < 128; i++) begin
      if (i == 50) begin
        word_count = 8'd3;
        start = 1'b1;
      end
      send(8'(i));
      start = 1'b0;
      send(8'h00);
      send(8'h00);
      send(8'h00);
      if (i == 50) begin
        chk("t4_mid_addr", mem_addr, 50);
        chk("t4_mid_hold", cpu_hold, 1);
        chk("t4_mid_err", error, 0);
      end
      if (i == 127) begin
        chk("t4_last_we", mem_we, 1);
        chk("t4_last_addr", mem_addr, 127);
        chk("t4_last_data", mem_wdata, 32'h0000007F);
      end
    end
    byte_valid = 1'b0;
    tick();
    chk("t4_done", done, 1);
    chk("t4_strobes", wr_cnt - base, 128);
    chk("t4_consec", consec, 0);
    chk("t4_mem64", shadow[64], 32'h00000040);
    chk("t4_mem127", shadow[127], 32'h0000007F);

    pulse_start(8'd2);
    send(8'hAA);
    send(8'hBB);
    base = wr_cnt;
    #3 rst_n = 1'b0;
    #2;
    chk("t5_ready", byte_ready, 0);
    chk("t5_hold", cpu_hold, 0);
    chk("t5_we", mem_we, 0);
    chk("t5_addr", mem_addr, 0);
    chk("t5_wdata", mem_wdata, 0);
    chk("t5_done", done, 0);
    repeat (3) tick();
    #3 rst_n = 1'b1;
    byte_valid = 1'b0;
    tick();
    chk("t5_no_we", wr_cnt - base, 0);
    pulse_start(8'd1);
    send_word(32'h11223344);
    chk("t5_re_we", mem_we, 1);
    chk("t5_re_addr", mem_addr, 0);
    chk("t5_re_data", mem_wdata, 32'h11223344);
    byte_valid = 1'b0;
    tick();
    chk("t5_re_done", done, 1);

    pulse_start(8'd2);
    send_word(32'h01020304);
    send_word(32'h05060708);
    chk("t6_addr1", mem_addr, 1);
    byte_valid = 1'b0;
    tick();
    chk("t6_done1", done, 1);
    pulse_start(8'd1);
    chk("t6_done_clr", done, 0);
    chk("t6_hold", cpu_hold, 1);
    send_word(32'h0BADC0DE);
    chk("t6_addr_restart", mem_addr, 0);
    chk("t6_data", mem_wdata, 32'h0BADC0DE);
    byte_valid = 1'b0;
    tick();
    chk("t6_done2", done, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
